// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// Time-multiplexed scan controller for common-anode 7-segment digits that share
// one BCD-to-7-segment decoder. Double-buffers the BCD value so the display only
// changes at frame boundaries, inserts an all-off gap between digits against
// ghosting, and computes leading-zero suppression itself because RBO cannot be
// chained across a multiplexed display.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 1000,
    parameter int GAP_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    lz_en,
    input  logic                    lamp_test,
    input  logic                    blank,
    output logic [NUM_DIGITS-1:0]   dig_n,
    output logic [3:0]              dec_bcd,
    output logic                    dec_lt,
    output logic                    dec_bi,
    output logic                    dec_rbi,
    output logic                    frame_done
);

    localparam int CNT_RANGE = (PRESCALE > GAP_CYCLES) ? PRESCALE : GAP_CYCLES;
    localparam int CNT_W     = $clog2((CNT_RANGE > 2) ? CNT_RANGE : 2);
    localparam int IDX_W     = $clog2(NUM_DIGITS);

    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t                  r_state, w_nxt_state;
    logic [IDX_W-1:0]        r_idx, w_nxt_idx;
    logic [CNT_W-1:0]        r_cnt, w_nxt_cnt;

    logic [4*NUM_DIGITS-1:0] r_pending, r_active, w_act_next;
    logic [NUM_DIGITS-1:0]   r_pend_mask, r_mask, w_mask_next, w_lz_mask;
    logic                    r_pend_flag;
    logic                    w_enter_drive, w_copy;

    logic [NUM_DIGITS-1:0]   r_dig_n, w_nxt_dig_n;
    logic [3:0]              r_bcd, w_nxt_bcd;
    logic                    r_lt, w_nxt_lt;
    logic                    r_bi, w_nxt_bi;
    logic                    r_rbi, w_nxt_rbi;
    logic                    r_fd, w_nxt_fd;

    assign dig_n      = r_dig_n;
    assign dec_bcd    = r_bcd;
    assign dec_lt     = r_lt;
    assign dec_bi     = r_bi;
    assign dec_rbi    = r_rbi;
    assign frame_done = r_fd;

    // Suppression mask of the incoming value: a digit is blanked while it and every more significant digit are zero; digit 0 always shows.
    always_comb begin
        logic v_run;
        w_lz_mask = '0;
        v_run     = lz_en;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            v_run        = v_run & (bcd_in[4*i +: 4] == 4'd0);
            w_lz_mask[i] = v_run;
        end
    end

    // Scan sequencing and next output values; outputs are computed from the next state so they are registered alongside it.
    always_comb begin
        logic v_adv;
        w_nxt_state   = r_state;
        w_nxt_idx     = r_idx;
        w_nxt_cnt     = r_cnt;
        w_nxt_fd      = 1'b0;
        w_enter_drive = 1'b0;
        v_adv         = 1'b0;

        if (!en) begin
            w_nxt_state = S_IDLE;
            w_nxt_idx   = IDX_TOP;
            w_nxt_cnt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_nxt_state   = S_DRIVE;
                    w_nxt_idx     = IDX_TOP;
                    w_nxt_cnt     = '0;
                    w_enter_drive = 1'b1;
                end
                S_DRIVE: begin
                    if (r_cnt == PRE_LAST) begin
                        if (GAP_CYCLES > 0) begin
                            w_nxt_state = S_GAP;
                            w_nxt_cnt   = '0;
                        end else begin
                            v_adv = 1'b1;
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        v_adv = 1'b1;
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_nxt_state = S_IDLE;
                    w_nxt_idx   = IDX_TOP;
                    w_nxt_cnt   = '0;
                end
            endcase
        end

        // Advancing from the last digit wraps to the MS digit and marks the frame boundary.
        if (v_adv) begin
            w_nxt_state   = S_DRIVE;
            w_nxt_cnt     = '0;
            w_enter_drive = 1'b1;
            if (r_idx == '0) begin
                w_nxt_idx = IDX_TOP;
                w_nxt_fd  = 1'b1;
            end else begin
                w_nxt_idx = r_idx - 1'b1;
            end
        end

        // Pending value becomes active only when a frame starts, so the display never tears.
        w_copy      = w_enter_drive && (w_nxt_idx == IDX_TOP) && r_pend_flag;
        w_act_next  = w_copy ? r_pending   : r_active;
        w_mask_next = w_copy ? r_pend_mask : r_mask;

        w_nxt_dig_n = '1;
        w_nxt_bcd   = r_bcd;
        w_nxt_lt    = r_lt;
        w_nxt_bi    = 1'b0;
        w_nxt_rbi   = r_rbi;
        if (w_nxt_state == S_DRIVE) begin
            w_nxt_dig_n[w_nxt_idx] = 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_nxt_idx == IDX_W'(i)) begin
                    w_nxt_bcd = w_act_next[4*i +: 4];
                end
            end
            w_nxt_rbi = ~w_mask_next[w_nxt_idx];
            w_nxt_lt  = ~lamp_test;
            w_nxt_bi  = lamp_test | ~blank;
        end
    end

    // State, digit index and dwell counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= IDX_TOP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_idx   <= w_nxt_idx;
            r_cnt   <= w_nxt_cnt;
        end
    end

    // Double buffer: loads land in pending; active and its mask update only at frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending   <= '0;
            r_pend_mask <= '0;
            r_pend_flag <= 1'b0;
            r_active    <= '0;
            r_mask      <= '0;
        end else begin
            if (load) begin
                r_pending   <= bcd_in;
                r_pend_mask <= w_lz_mask;
                r_pend_flag <= 1'b1;
            end else if (w_copy) begin
                r_pend_flag <= 1'b0;
            end
            r_active <= w_act_next;
            r_mask   <= w_mask_next;
        end
    end

    // Registered decoder and digit-select outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dig_n <= '1;
            r_bcd   <= 4'd0;
            r_lt    <= 1'b1;
            r_bi    <= 1'b0;
            r_rbi   <= 1'b1;
            r_fd    <= 1'b0;
        end else begin
            r_dig_n <= w_nxt_dig_n;
            r_bcd   <= w_nxt_bcd;
            r_lt    <= w_nxt_lt;
            r_bi    <= w_nxt_bi;
            r_rbi   <= w_nxt_rbi;
            r_fd    <= w_nxt_fd;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Testbench for seven_seg_scan_ctrl (NUM_DIGITS=4, PRESCALE=4, GAP_CYCLES=1).
// Expected per-cycle outputs are queued when stimulus is set up and popped as
// the controller produces each cycle.
module tb_seven_seg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] bcd_in;
    logic        lz_en;
    logic        lamp_test;
    logic        blank;
    logic [3:0]  dig_n;
    logic [3:0]  dec_bcd;
    logic        dec_lt;
    logic        dec_bi;
    logic        dec_rbi;
    logic        frame_done;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(4),
        .PRESCALE  (4),
        .GAP_CYCLES(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .bcd_in    (bcd_in),
        .lz_en     (lz_en),
        .lamp_test (lamp_test),
        .blank     (blank),
        .dig_n     (dig_n),
        .dec_bcd   (dec_bcd),
        .dec_lt    (dec_lt),
        .dec_bi    (dec_bi),
        .dec_rbi   (dec_rbi),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dig_n;
        logic [3:0] bcd;
        logic       lt;
        logic       bi;
        logic       rbi;
        logic       fd;
        bit         drv;
        bit         chk_bcd;
    } exp_t;

    typedef struct {
        logic [15:0] val;
        logic        lz;
        logic [3:0]  rbi;
    } vec_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic push_rec(input logic [3:0] dn, input logic [3:0] bcd, input logic lt,
                            input logic bi, input logic rbi, input logic fd,
                            input bit drv, input bit cb);
        exp_t e;
        e.dig_n = dn; e.bcd = bcd; e.lt = lt; e.bi = bi; e.rbi = rbi; e.fd = fd;
        e.drv = drv; e.chk_bcd = cb;
        sb.push_back(e);
    endtask

    task automatic push_idle();
        push_rec(4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // One full frame: each digit driven 4 cycles from MS down, then one all-off cycle holding dec_bcd.
    task automatic push_frame(input logic [15:0] v, input logic [3:0] rbi, input bit fd0,
                              input bit blk, input bit lt);
        logic [3:0] dn;
        logic [3:0] nib;
        for (int d = 3; d >= 0; d--) begin
            dn    = 4'hF;
            dn[d] = 1'b0;
            nib   = v[d*4 +: 4];
            for (int c = 0; c < 4; c++)
                push_rec(dn, nib, ~lt, lt | ~blk, rbi[d], (d == 3 && c == 0) ? fd0 : 1'b0, 1'b1, 1'b1);
            push_rec(4'hF, nib, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic step(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("dig_n", dig_n, e.dig_n);
                chk("dec_bi", {3'b0, dec_bi}, {3'b0, e.bi});
                chk("frame_done", {3'b0, frame_done}, {3'b0, e.fd});
                if (e.chk_bcd) chk("dec_bcd", dec_bcd, e.bcd);
                if (e.drv) begin
                    chk("dec_lt", {3'b0, dec_lt}, {3'b0, e.lt});
                    chk("dec_rbi", {3'b0, dec_rbi}, {3'b0, e.rbi});
                end
            end
        end
    endtask

    task automatic load_idle(input logic [15:0] v, input logic lz);
        bcd_in = v;
        lz_en  = lz;
        load   = 1'b1;
        push_idle();
        step(1);
        load = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dig_n"}, dig_n, 4'hF);
        chk({tag, "_bcd"}, dec_bcd, 4'h0);
        chk({tag, "_lt"}, {3'b0, dec_lt}, 4'h1);
        chk({tag, "_bi"}, {3'b0, dec_bi}, 4'h0);
        chk({tag, "_rbi"}, {3'b0, dec_rbi}, 4'h1);
        chk({tag, "_fd"}, {3'b0, frame_done}, 4'h0);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{val: 16'h0042, lz: 1'b1, rbi: 4'b0011};
        tbl[1] = '{val: 16'h0000, lz: 1'b1, rbi: 4'b0001};
        tbl[2] = '{val: 16'h0000, lz: 1'b0, rbi: 4'b1111};
        tbl[3] = '{val: 16'h5678, lz: 1'b1, rbi: 4'b1111};
        tbl[4] = '{val: 16'h0F09, lz: 1'b1, rbi: 4'b0111};
        tbl[5] = '{val: 16'h0100, lz: 1'b1, rbi: 4'b0111};
        tbl[6] = '{val: 16'h0007, lz: 1'b1, rbi: 4'b0001};

        rst = 1'b1; en = 1'b0; load = 1'b0; bcd_in = 16'h0; lz_en = 1'b0;
        lamp_test = 1'b0; blank = 1'b0;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Table: load from idle, scan two frames plus the first cycle of a third, then drop en mid-DRIVE.
        for (int i = 0; i < 7; i++) begin
            load_idle(tbl[i].val, tbl[i].lz);
            en = 1'b1;
            push_frame(tbl[i].val, tbl[i].rbi, 1'b0, 1'b0, 1'b0);
            push_frame(tbl[i].val, tbl[i].rbi, 1'b1, 1'b0, 1'b0);
            push_rec(4'b0111, tbl[i].val[15:12], 1'b1, 1'b1, tbl[i].rbi[3], 1'b1, 1'b1, 1'b1);
            step(41);
            en = 1'b0;
            push_idle();
            step(1);
        end

        // Load during digit 1 takes effect next frame; of two loads in one frame only the last shows.
        load_idle(16'h5678, 1'b0);
        en = 1'b1;
        push_frame(16'h5678, 4'b1111, 1'b0, 1'b0, 1'b0);
        push_frame(16'h1234, 4'b1111, 1'b1, 1'b0, 1'b0);
        step(12);
        bcd_in = 16'h1234; load = 1'b1;
        step(1);
        load = 1'b0;
        step(27);
        push_frame(16'h1234, 4'b1111, 1'b1, 1'b0, 1'b0);
        push_frame(16'h9876, 4'b1111, 1'b1, 1'b0, 1'b0);
        step(3);
        bcd_in = 16'h1111; load = 1'b1;
        step(1);
        load = 1'b0;
        step(5);
        bcd_in = 16'h9876; load = 1'b1;
        step(1);
        load = 1'b0;
        step(30);
        en = 1'b0;
        push_idle();
        step(1);

        // Blank, then lamp test on top of blank.
        load_idle(16'h0305, 1'b1);
        blank = 1'b1;
        en    = 1'b1;
        push_frame(16'h0305, 4'b0111, 1'b0, 1'b1, 1'b0);
        push_frame(16'h0305, 4'b0111, 1'b1, 1'b1, 1'b1);
        step(20);
        lamp_test = 1'b1;
        step(20);
        lamp_test = 1'b0;
        blank     = 1'b0;
        en        = 1'b0;
        push_idle();
        step(1);

        // Asynchronous reset while digit 2 is driven; scan restarts at digit 3 with cleared buffers.
        en = 1'b1;
        for (int c = 0; c < 4; c++) push_rec(4'b0111, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        push_rec(4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 2; c++) push_rec(4'b1011, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step(7);
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_frame(16'h0000, 4'b1111, 1'b0, 1'b0, 1'b0);
        step(20);
        en = 1'b0;
        push_idle();
        step(1);

        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one BCD-to-7-segment decoder.
- Holds a multi-digit BCD value in a double-buffered register and selects one digit at a time.
- Drives the shared decoder's D/C/B/A, LT, BI and RBI inputs.
- Inserts an all-off dead gap between digits to prevent ghosting, and performs leading-zero suppression internally, because a multiplexed display cannot chain RBO between digits.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2)
PRESCALE, 1000, clk cycles each digit is driven (>=1)
GAP_CYCLES, 2, clk cycles of all-off gap after each digit (0 = no gap)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  scan enable
load  input  1  capture bcd_in into the pending buffer
bcd_in  input  4*NUM_DIGITS  BCD digits; [3:0] = digit 0 (LS), top nibble = MS
lz_en  input  1  leading-zero suppression enable, sampled with load
lamp_test  input  1  force all segments on
blank  input  1  blank the display; scan continues
dig_n  output  NUM_DIGITS  active-low one-hot digit select
dec_bcd  output  4  to decoder {D,C,B,A}
dec_lt  output  1  to decoder LT (0 = lamp test)
dec_bi  output  1  to decoder BI (0 = blank)
dec_rbi  output  1  to decoder RBI (1 = show zero, 0 = blank a zero)
frame_done  output  1  one-cycle pulse at the end of each full frame

Behaviour:
- All outputs are registered and change only on rising clk, except on rst.
- Reset values, applied immediately on rst=1:
  - dig_n = all 1s, dec_bcd = 0, dec_lt = 1, dec_bi = 0, dec_rbi = 1, frame_done = 0.
  - state = IDLE, idx = NUM_DIGITS-1, pending and active buffers = 0, suppression masks = 0, pend_flag = 0.
- Load path:
  - When load=1, pending <= bcd_in and pend_flag <= 1.
  - Suppression mask is computed at the same edge: bit i = lz_en AND every digit from MS down to i is 0.
  - Bit 0 is always 0, so an all-zero value shows a single "0".
  - A second load before frame start overwrites pending; the last load wins.
- Frame-start copy: on entry to DRIVE with idx = NUM_DIGITS-1, if pend_flag=1 then active <= pending, mask <= pending mask, pend_flag <= 0. A load in that same cycle sets pend_flag again; the new value waits for the next frame. The displayed value never changes mid-frame.
- State machine (counter width = clog2 of max(PRESCALE, GAP_CYCLES, 2)):
  - IDLE: dig_n all 1s, dec_bi = 0. If en=1, go to DRIVE with idx = NUM_DIGITS-1 and counter = 0.
  - DRIVE: held for exactly PRESCALE cycles.
    - dig_n[idx] = 0, all other bits 1.
    - dec_bcd = active nibble idx.
    - dec_rbi = ~mask[idx].
    - dec_lt = ~lamp_test.
    - dec_bi = lamp_test | ~blank.
    - On the last cycle: go to GAP if GAP_CYCLES > 0, else advance directly.
  - GAP: held for GAP_CYCLES cycles. dig_n all 1s, dec_bi = 0, dec_bcd holds its value. Then advance.
  - Advance: if idx = 0, set idx = NUM_DIGITS-1 and assert frame_done for one cycle, coincident with the first DRIVE cycle of the new frame. Otherwise idx = idx-1. Then enter DRIVE.
- Frame period = NUM_DIGITS*(PRESCALE+GAP_CYCLES) cycles.
- en=0 in any state: next edge goes to IDLE with dig_n all 1s. idx and counter reset to IDLE values, and no frame_done is produced. Loads are still accepted while idle.
- lamp_test overrides blank: BI is forced high so the decoder's LT takes effect. The scan continues, and lamp_test does not alter the buffers.
- dec_bcd values above 9 are passed through unchanged; the decoder defines their glyphs. The controller does not validate BCD.
- rst asserted mid-operation: outputs go to reset values asynchronously. After release, scanning restarts from IDLE.

Test Plan:
- Parameters for all scenarios: NUM_DIGITS=4, PRESCALE=4, GAP_CYCLES=1.
- Reset mid-DRIVE of digit 2 -> dig_n=4'b1111 and dec_bi=0 before the next edge; the first DRIVE after release selects digit 3.
- Load 16'h0042 with lz_en=1, then en=1:
  - digits 3 and 2 show dec_rbi=0, dec_bcd=0;
  - digit 1 shows dec_bcd=4, dec_rbi=1;
  - digit 0 shows dec_bcd=2, dec_rbi=1;
  - each digit drives dig_n low for 4 cycles followed by 1 all-off cycle;
  - frame_done pulses every 20 cycles.
- Load 16'h0000 with lz_en=1 -> digits 3..1 show dec_rbi=0, digit 0 shows dec_rbi=1, dec_bcd=0. With lz_en=0, every digit shows dec_rbi=1.
- Load 16'h1234 during digit 1 of a frame showing 16'h5678 -> digits 1 and 0 still show 7 and 8; 1,2,3,4 appear from the next frame. Two loads within one frame -> only the second is displayed.
- blank=1 -> dec_bi=0 and digit scan unchanged. Then lamp_test=1 with blank=1 -> dec_lt=0 and dec_bi=1 during DRIVE, dec_bi=0 during GAP.
- en deasserted mid-DRIVE -> next edge dig_n=4'b1111 with no frame_done. Re-enable -> restart at digit 3, and the first frame_done arrives 20 cycles later.
